keypad_scan_decoder: RTL

- Scans a 4x4 matrix keypad by driving one column low at a time and sampling the active-low row lines.
- Debounces presses and releases, then emits a single-cycle hex key code strobe.
- Sits directly upstream of the operand-entry/divider top: its key_code/key_valid feed the digit assembler that builds A and B.

---
 rtl/keypad_scan_decoder.sv | 211 +++++++++++++++++++++
 1 files changed

// File: rtl/keypad_scan_decoder.sv
// keypad_scan_decoder
//   Scans a 4x4 matrix keypad one column at a time. Rows are sampled through
//   a two-flop synchronizer. Presses and releases are debounced. Each accepted
//   key produces a one-cycle hex code strobe for the downstream digit assembler.
//
//   Optional build macro: KEYPAD_AUTOREPEAT_EN
//     When defined, a held key re-strobes key_valid every REPEAT_CYCLES cycles.
//
// Ports
//   clk          system clock
//   rst          synchronous, active-high reset
//   fil[3:0]     keypad rows, active-low, asynchronous (fil[3] = row 0)
//   col[3:0]     keypad columns; exactly one bit is driven low
//   key_code     hex code of the last accepted key (held until next accept)
//   key_valid    one-cycle strobe when key_code is updated
//   key_pressed  high while an accepted key is still held
module keypad_scan_decoder #(
  parameter int SCAN_CYCLES     = 500,
  parameter int DEBOUNCE_CYCLES = 1000,
  parameter int REPEAT_CYCLES   = 25000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] fil,
  output logic [3:0] col,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_pressed
);

  // A single counter serves both the scan window and the debounce intervals.
  localparam int CNT_MAX = (SCAN_CYCLES > DEBOUNCE_CYCLES) ? SCAN_CYCLES : DEBOUNCE_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX);
  localparam logic [CNT_W-1:0] SCAN_LAST = CNT_W'(SCAN_CYCLES - 1);
  localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);

  // Elaboration-time guards on parameter minimums.
  if (SCAN_CYCLES < 4) begin : g_bad_scan
    $error("keypad_scan_decoder: SCAN_CYCLES must be at least 4");
  end
  if (DEBOUNCE_CYCLES < 2) begin : g_bad_debounce
    $error("keypad_scan_decoder: DEBOUNCE_CYCLES must be at least 2");
  end
  if (REPEAT_CYCLES < 2) begin : g_bad_repeat
    $error("keypad_scan_decoder: REPEAT_CYCLES must be at least 2");
  end

  typedef enum logic [1:0] {SCAN, DEBOUNCE, PRESSED, RELEASE} state_t;

  state_t           state, state_nx;
  logic [3:0]       sync_meta, fs;
  logic [1:0]       col_idx, col_idx_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic [3:0]       row_pat, row_pat_nx;
  logic [3:0]       key_code_nx;
  logic             key_valid_nx;

`ifdef KEYPAD_AUTOREPEAT_EN
  localparam int REP_W = $clog2(REPEAT_CYCLES);
  localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_CYCLES - 1);
  logic [REP_W-1:0] rep_cnt, rep_cnt_nx;
`endif

  // Row pattern (single low bit) plus column index -> hex key code.
  function automatic logic [3:0] decode_key(input logic [3:0] pat, input logic [1:0] c);
    logic [1:0] row;
    logic [3:0] code;
    case (pat)
      4'b0111: row = 2'd0;
      4'b1011: row = 2'd1;
      4'b1101: row = 2'd2;
      default: row = 2'd3;
    endcase
    case ({row, c})
      4'b00_00: code = 4'h1;
      4'b00_01: code = 4'h2;
      4'b00_10: code = 4'h3;
      4'b00_11: code = 4'hA;
      4'b01_00: code = 4'h4;
      4'b01_01: code = 4'h5;
      4'b01_10: code = 4'h6;
      4'b01_11: code = 4'hB;
      4'b10_00: code = 4'h7;
      4'b10_01: code = 4'h8;
      4'b10_10: code = 4'h9;
      4'b10_11: code = 4'hC;
      4'b11_00: code = 4'hE;
      4'b11_01: code = 4'hF;
      4'b11_10: code = 4'hD;
      default:  code = 4'h0;
    endcase
    return code;
  endfunction

  assign col         = ~(4'b0001 << col_idx);
  assign key_pressed = (state == PRESSED);

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_meta <= 4'b1111;
      fs        <= 4'b1111;
    end else begin
      sync_meta <= fil;
      fs        <= sync_meta;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= SCAN;
      col_idx   <= 2'd0;
      cnt       <= '0;
      row_pat   <= 4'b1111;
      key_code  <= 4'h0;
      key_valid <= 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
      rep_cnt   <= '0;
`endif
    end else begin
      state     <= state_nx;
      col_idx   <= col_idx_nx;
      cnt       <= cnt_nx;
      row_pat   <= row_pat_nx;
      key_code  <= key_code_nx;
      key_valid <= key_valid_nx;
`ifdef KEYPAD_AUTOREPEAT_EN
      rep_cnt   <= rep_cnt_nx;
`endif
    end
  end

  always_comb begin
    state_nx     = state;
    col_idx_nx   = col_idx;
    cnt_nx       = cnt;
    row_pat_nx   = row_pat;
    key_code_nx  = key_code;
    key_valid_nx = 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
    rep_cnt_nx   = rep_cnt;
`endif
    case (state)
      SCAN: begin
        if (cnt == SCAN_LAST) begin
          cnt_nx = '0;
          // Only a single low row is a usable candidate; ghosting or
          // multi-key patterns just move the scan on.
          if ($onehot(~fs)) begin
            row_pat_nx = fs;
            state_nx   = DEBOUNCE;
          end else begin
            col_idx_nx = col_idx + 2'd1;
          end
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      DEBOUNCE: begin
        if (fs == row_pat) begin
          if (cnt == DEB_LAST) begin
            key_code_nx  = decode_key(row_pat, col_idx);
            key_valid_nx = 1'b1;
            cnt_nx       = '0;
            state_nx     = PRESSED;
`ifdef KEYPAD_AUTOREPEAT_EN
            rep_cnt_nx   = '0;
`endif
          end else begin
            cnt_nx = cnt + 1'b1;
          end
        end else begin
          cnt_nx     = '0;
          col_idx_nx = col_idx + 2'd1;
          state_nx   = SCAN;
        end
      end
      PRESSED: begin
        // The counter measures an unbroken run of all-high rows.
        if (fs == 4'b1111) begin
          if (cnt == DEB_LAST) begin
            cnt_nx   = '0;
            state_nx = RELEASE;
          end else begin
            cnt_nx = cnt + 1'b1;
          end
        end else begin
          cnt_nx = '0;
        end
`ifdef KEYPAD_AUTOREPEAT_EN
        if (fs != 4'b1111) begin
          if (rep_cnt == REP_LAST) begin
            rep_cnt_nx   = '0;
            key_valid_nx = 1'b1;
          end else begin
            rep_cnt_nx = rep_cnt + 1'b1;
          end
        end
`endif
      end
      RELEASE: begin
        cnt_nx     = '0;
        col_idx_nx = col_idx + 2'd1;
        state_nx   = SCAN;
      end
      default: begin
        state_nx = SCAN;
      end
    endcase
  end

endmodule
